// File: rtl/im_loader_ctrl.sv
// im_loader_ctrl: writes upstream instruction words into consecutive IM addresses, then releases the CPU.
// Latency: IM write one cycle after each accept; DONE two cycles after the final accept.
// Backpressure: in_ready is high only in LOAD/CHECK, so the source stalls in all other states.
// Optional checksum word after the program: define IM_LOADER_CHECKSUM_EN to enable it.
module im_loader_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_wdata,
  output logic              busy,
  output logic              done,
  output logic              cpu_run,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_last;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_done;

  logic w_ready;
  logic w_accept;
  logic w_data_acc;
  logic w_start;

  // Handshake decode: a data accept is only one taken in LOAD; a start only counts in IDLE/DONE.
  assign w_ready    = (r_state == S_LOAD) || (r_state == S_CHECK);
  assign w_accept   = in_valid & w_ready;
  assign w_data_acc = w_accept & (r_state == S_LOAD);
  assign w_start    = start & ((r_state == S_IDLE) || (r_state == S_DONE));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_LOAD;
      S_LOAD: begin
        if (w_data_acc && (r_cnt == r_last)) begin
`ifdef IM_LOADER_CHECKSUM_EN
          w_next = S_CHECK;
`else
          w_next = S_FLUSH;
`endif
        end
      end
      S_CHECK: if (w_accept) w_next = S_FLUSH;
      S_FLUSH: w_next = S_DONE;
      S_DONE:  if (w_start) w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: word counter, registered IM write port and the DONE-entry pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_last  <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_done  <= 1'b0;
    end else begin
      r_we   <= w_data_acc;
      r_done <= (r_state == S_FLUSH);
      if (w_start) begin
        r_last <= last_addr;
        r_cnt  <= '0;
      end
      if (w_data_acc) begin
        r_addr  <= r_cnt;
        r_wdata <= in_data;
        r_cnt   <= r_cnt + ADDR_W'(1);
      end
    end
  end

`ifdef IM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_acc;
  logic              r_err;

  // Running sum of program words; the word taken in CHECK is compared against it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_start) begin
        r_acc <= '0;
        r_err <= 1'b0;
      end else if (w_data_acc) begin
        r_acc <= r_acc + in_data;
      end else if (w_accept && (r_state == S_CHECK)) begin
        r_err <= (r_acc != in_data);
      end
    end
  end
`endif

  // Output decode from state and registered datapath.
  always_comb begin
    in_ready = w_ready;
    busy     = (r_state == S_LOAD) || (r_state == S_CHECK) || (r_state == S_FLUSH);
    im_we    = r_we;
    im_addr  = r_addr;
    im_wdata = r_wdata;
    done     = r_done;
`ifdef IM_LOADER_CHECKSUM_EN
    err      = r_err;
`else
    err      = 1'b0;
`endif
    cpu_run  = (r_state == S_DONE) && !err;
  end

endmodule
